// File: rtl/mouse_pos_tracker_pkg.sv
// Shared constants, FSM state type and PS/2 delta decoding for the mouse position tracker.
package mouse_pos_tracker_pkg;

    localparam int unsigned PosW     = 12;
    localparam int unsigned DefMaxX  = 1019;
    localparam int unsigned DefMaxY  = 763;
    localparam int unsigned GameMaxX = 800;
    localparam int unsigned GameMaxY = 600;
    localparam int unsigned MenuMaxX = 1019;
    localparam int unsigned MenuMaxY = 763;

    // Signed width able to hold +255, -256 and the negated -(-256) = +256.
    localparam int unsigned DeltaW = 10;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StApplyX = 3'd1,
        StApplyY = 3'd2,
        StDone   = 3'd3,
        StClamp  = 3'd4
    } state_e;

    // An overflowed packet saturates toward its sign instead of trusting the 9-bit field.
    function automatic logic signed [DeltaW-1:0] delta_eff(input logic [8:0] d,
                                                            input logic       ovf);
        if (ovf) begin
            return d[8] ? -10'sd256 : 10'sd255;
        end
        return {d[8], d};
    endfunction

endpackage

// File: rtl/mouse_axis_clamp.sv
// Combinational single-axis update: pos + delta, saturated into [0, bound].
module mouse_axis_clamp
    import mouse_pos_tracker_pkg::*;
#(
    parameter int unsigned W = PosW
) (
    input  logic [W-1:0]              pos,
    input  logic signed [DeltaW-1:0]  delta,
    input  logic [W-1:0]              bound,
    output logic [W-1:0]              pos_sat
);

    logic signed [W+1:0] sum;
    logic signed [W+1:0] bound_s;

    assign bound_s = $signed({2'b00, bound});
    assign sum     = $signed({2'b00, pos}) + $signed({{(W + 2 - DeltaW){delta[DeltaW-1]}}, delta});

    always_comb begin
        if (sum < 0) begin
            pos_sat = '0;
        end else if (sum > bound_s) begin
            pos_sat = bound;
        end else begin
            pos_sat = sum[W-1:0];
        end
    end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Absolute cursor tracker: applies relative PS/2 moves and bound/position set strobes,
// keeping xpos/ypos saturated inside [0, max_x] x [0, max_y].
module mouse_pos_tracker
    import mouse_pos_tracker_pkg::*;
#(
    parameter int unsigned W         = PosW,
    parameter int unsigned DEF_MAX_X = DefMaxX,
    parameter int unsigned DEF_MAX_Y = DefMaxY
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] value,
    input  logic         setx,
    input  logic         sety,
    input  logic         setmax_x,
    input  logic         setmax_y,
    input  logic         move_valid,
    input  logic [8:0]   dx,
    input  logic [8:0]   dy,
    input  logic         x_ovf,
    input  logic         y_ovf,
    output logic [W-1:0] xpos,
    output logic [W-1:0] ypos,
    output logic [W-1:0] max_x,
    output logic [W-1:0] max_y,
    output logic         pos_valid,
    output logic         busy,
    output logic         drop
);

    state_e state_q, state_d;

    logic [W-1:0] xpos_q, xpos_d;
    logic [W-1:0] ypos_q, ypos_d;
    logic [W-1:0] max_x_q, max_x_d;
    logic [W-1:0] max_y_q, max_y_d;
    logic         pos_valid_q, pos_valid_d;
    logic         drop_q, drop_d;

    logic signed [DeltaW-1:0] dx_q, dx_d;
    logic signed [DeltaW-1:0] dy_neg_q, dy_neg_d;

    logic [W-1:0]             max_x_eff, max_y_eff;
    logic [W-1:0]             set_x_val, set_y_val;
    logic [W-1:0]             x_sat, y_sat;
    logic signed [DeltaW-1:0] x_delta, y_delta;

    // Bounds written this cycle already govern any position written this cycle.
    assign max_x_eff = setmax_x ? value : max_x_q;
    assign max_y_eff = setmax_y ? value : max_y_q;
    assign set_x_val = (value < max_x_eff) ? value : max_x_eff;
    assign set_y_val = (value < max_y_eff) ? value : max_y_eff;

    // A zero delta turns the saturator into a plain min(), which is what CLAMP needs.
    assign x_delta = (state_q == StApplyX) ? dx_q : '0;
    assign y_delta = (state_q == StApplyY) ? dy_neg_q : '0;

    mouse_axis_clamp #(
        .W (W)
    ) u_clamp_x (
        .pos     (xpos_q),
        .delta   (x_delta),
        .bound   (max_x_eff),
        .pos_sat (x_sat)
    );

    mouse_axis_clamp #(
        .W (W)
    ) u_clamp_y (
        .pos     (ypos_q),
        .delta   (y_delta),
        .bound   (max_y_eff),
        .pos_sat (y_sat)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (move_valid) begin
                    state_d = StApplyX;
                end else if ((xpos_q > max_x_q) || (ypos_q > max_y_q)) begin
                    state_d = StClamp;
                end
            end
            StApplyX: state_d = StApplyY;
            StApplyY: state_d = StDone;
            StDone:   state_d = StIdle;
            StClamp:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        dx_d        = dx_q;
        dy_neg_d    = dy_neg_q;
        drop_d      = drop_q;
        max_x_d     = max_x_eff;
        max_y_d     = max_y_eff;
        xpos_d      = xpos_q;
        ypos_d      = ypos_q;
        pos_valid_d = (state_q == StApplyY) || (state_q == StClamp);

        if (move_valid) begin
            if (state_q == StIdle) begin
                dx_d     = delta_eff(dx, x_ovf);
                dy_neg_d = -delta_eff(dy, y_ovf);
            end else begin
                drop_d = 1'b1;
            end
        end

        if ((state_q == StApplyX) || (state_q == StClamp)) begin
            xpos_d = x_sat;
        end
        if ((state_q == StApplyY) || (state_q == StClamp)) begin
            ypos_d = y_sat;
        end

        // Explicit set strobes override any move/clamp write on the same axis.
        if (setx) begin
            xpos_d = set_x_val;
        end
        if (sety) begin
            ypos_d = set_y_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            xpos_q      <= '0;
            ypos_q      <= '0;
            max_x_q     <= W'(DEF_MAX_X);
            max_y_q     <= W'(DEF_MAX_Y);
            pos_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            dx_q        <= '0;
            dy_neg_q    <= '0;
        end else begin
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            max_x_q     <= max_x_d;
            max_y_q     <= max_y_d;
            pos_valid_q <= pos_valid_d;
            drop_q      <= drop_d;
            dx_q        <= dx_d;
            dy_neg_q    <= dy_neg_d;
        end
    end

    assign xpos      = xpos_q;
    assign ypos      = ypos_q;
    assign max_x     = max_x_q;
    assign max_y     = max_y_q;
    assign pos_valid = pos_valid_q;
    assign busy      = (state_q != StIdle);
    assign drop      = drop_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Directed and randomized checks of mouse_pos_tracker against an arithmetic reference model.
module tb_mouse_pos_tracker;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] value = '0;
    logic         setx = 1'b0, sety = 1'b0, setmax_x = 1'b0, setmax_y = 1'b0;
    logic         move_valid = 1'b0;
    logic [8:0]   dx = '0, dy = '0;
    logic         x_ovf = 1'b0, y_ovf = 1'b0;
    logic [W-1:0] xpos, ypos, max_x, max_y;
    logic         pos_valid, busy, drop;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_x, m_y, m_mx, m_my;

    mouse_pos_tracker dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .setx       (setx),
        .sety       (sety),
        .setmax_x   (setmax_x),
        .setmax_y   (setmax_y),
        .move_valid (move_valid),
        .dx         (dx),
        .dy         (dy),
        .x_ovf      (x_ovf),
        .y_ovf      (y_ovf),
        .xpos       (xpos),
        .ypos       (ypos),
        .max_x      (max_x),
        .max_y      (max_y),
        .pos_valid  (pos_valid),
        .busy       (busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input logic [8:0] d, input logic ovf);
        int raw;
        raw = int'(d);
        if (ovf) return (raw >= 256) ? -256 : 255;
        return (raw >= 256) ? raw - 512 : raw;
    endfunction

    function automatic int sat(input int v, input int m);
        if (v < 0) return 0;
        if (v > m) return m;
        return v;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_mx = 1019; m_my = 763;
    endtask

    // One cycle of config strobes; model applies new bounds before clamping set values.
    task automatic set_cfg(input bit sx, input bit sy, input bit smx, input bit smy,
                           input int val);
        value = W'(val); setx = sx; sety = sy; setmax_x = smx; setmax_y = smy;
        if (smx) m_mx = val;
        if (smy) m_my = val;
        if (sx) m_x = min2(val, m_mx);
        if (sy) m_y = min2(val, m_my);
        tick();
        setx = 0; sety = 0; setmax_x = 0; setmax_y = 0;
    endtask

    task automatic do_move(input logic [8:0] mdx, input logic [8:0] mdy,
                           input logic mxo, input logic myo);
        int ex, ey;
        ex = sat(m_x + eff(mdx, mxo), m_mx);
        ey = sat(m_y - eff(mdy, myo), m_my);
        dx = mdx; dy = mdy; x_ovf = mxo; y_ovf = myo; move_valid = 1;
        tick();
        move_valid = 0; x_ovf = 0; y_ovf = 0;
        check("busy_apply", busy, 1);
        tick();
        check("xpos_n2", xpos, ex);
        check("ypos_n2_old", ypos, m_y);
        tick();
        check("ypos_n3", ypos, ey);
        check("pos_valid_n3", pos_valid, 1);
        tick();
        check("pos_valid_n4", pos_valid, 0);
        check("busy_n4", busy, 0);
        m_x = ex; m_y = ey;
    endtask

    initial begin
        int ex, ey, pv_seen;
        model_reset();

        // Reset state
        rst = 1; tick(); tick(); rst = 0;
        check("rst_xpos", xpos, m_x);
        check("rst_ypos", ypos, m_y);
        check("rst_max_x", max_x, 1019);
        check("rst_max_y", max_y, 763);
        check("rst_busy", busy, 0);
        check("rst_drop", drop, 0);
        check("rst_pos_valid", pos_valid, 0);

        // Back-to-back bound writes
        value = 800; setmax_x = 1; tick();
        check("bounds_pv1", pos_valid, 0);
        setmax_x = 0; value = 600; setmax_y = 1; tick();
        setmax_y = 0; m_mx = 800; m_my = 600;
        check("bounds_pv2", pos_valid, 0);
        check("bounds_max_x", max_x, 800);
        check("bounds_max_y", max_y, 600);
        tick();
        check("bounds_pv3", pos_valid, 0);

        // Basic move with latency
        set_cfg(1, 0, 0, 0, 500);
        set_cfg(0, 1, 0, 0, 300);
        check("set_xpos", xpos, 500);
        check("set_ypos", ypos, 300);
        do_move(9'd20, 9'd10, 0, 0);

        // Saturation and overflow
        set_cfg(1, 0, 0, 0, 790);
        do_move(9'd100, 9'd0, 0, 0);
        set_cfg(0, 1, 0, 0, 5);
        do_move(9'd0, 9'd50, 0, 0);
        set_cfg(1, 0, 0, 0, 100);
        do_move(9'h1F0, 9'd0, 1, 0);
        check("ovf_neg_x", xpos, 0);
        set_cfg(0, 1, 0, 0, 300);
        do_move(9'd3, 9'h010, 0, 1);

        // Lowering the bound under the cursor triggers CLAMP
        set_cfg(0, 0, 1, 0, 1019);
        set_cfg(1, 0, 0, 0, 1000);
        set_cfg(0, 0, 1, 0, 800);
        check("clamp_c1_xpos", xpos, 1000);
        check("clamp_c1_busy", busy, 0);
        tick();
        check("clamp_c2_busy", busy, 1);
        tick();
        check("clamp_c3_xpos", xpos, 800);
        check("clamp_c3_pv", pos_valid, 1);
        check("clamp_c3_busy", busy, 0);
        tick();
        check("clamp_c4_pv", pos_valid, 0);
        m_x = 800;

        // setmax_x with setx in one cycle clamps to the new bound
        set_cfg(1, 0, 1, 0, 700);
        check("set_and_max_x", xpos, 700);
        check("set_and_max_mx", max_x, 700);
        tick(); tick();
        set_cfg(0, 0, 1, 0, 800);

        // Bound of zero pins the axis
        set_cfg(0, 0, 1, 0, 0);
        tick(); tick(); tick();
        m_x = 0;
        check("max0_xpos", xpos, 0);
        do_move(9'd30, 9'd0, 0, 0);
        set_cfg(0, 0, 1, 0, 800);

        // Config strobe together with move in IDLE: move sees the new position
        value = 50; setx = 1; dx = 9'd10; dy = 9'd0; move_valid = 1; tick();
        setx = 0; move_valid = 0;
        tick();
        check("cfg_move_xpos", xpos, 60);
        tick(); tick();
        m_x = 60;

        // setx during APPLY_X wins the x write; y still moves
        set_cfg(0, 1, 0, 0, 100);
        ey = sat(m_y - 20, m_my);
        dx = 9'd50; dy = 9'd20; move_valid = 1; tick();
        move_valid = 0; value = 7; setx = 1; tick();
        setx = 0;
        check("setx_wins_x", xpos, 7);
        tick();
        check("setx_wins_y", ypos, ey);
        check("setx_wins_pv", pos_valid, 1);
        tick();
        m_x = 7; m_y = ey;

        // Move while busy is dropped
        ex = sat(m_x + 40, m_mx);
        ey = sat(m_y - 0, m_my);
        dx = 9'd40; dy = 9'd0; move_valid = 1; tick();
        dx = 9'd200; move_valid = 1; tick();
        move_valid = 0;
        check("drop_xpos", xpos, ex);
        check("drop_flag", drop, 1);
        tick(); tick(); tick(); tick();
        check("drop_xpos_final", xpos, ex);
        check("drop_ypos_final", ypos, ey);
        check("drop_sticky", drop, 1);
        m_x = ex;

        // Reset in the middle of APPLY_X
        dx = 9'd5; move_valid = 1; tick();
        move_valid = 0; rst = 1; tick();
        rst = 0;
        model_reset();
        check("midrst_xpos", xpos, 0);
        check("midrst_max_x", max_x, 1019);
        check("midrst_max_y", max_y, 763);
        check("midrst_busy", busy, 0);
        check("midrst_drop", drop, 0);
        pv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pos_valid) pv_seen++;
        end
        check("midrst_no_pv", pv_seen, 0);
        check("midrst_xpos_held", xpos, 0);

        // Randomized moves, set strobes and bound changes
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    set_cfg(0, 0, 1, 0, 800);
                    set_cfg(0, 0, 0, 1, 600);
                end else begin
                    set_cfg(0, 0, 1, 0, 1019);
                    set_cfg(0, 0, 0, 1, 763);
                end
                for (int k = 0; k < 5; k++) tick();
                m_x = min2(m_x, m_mx);
                m_y = min2(m_y, m_my);
                check("rand_settle_x", xpos, m_x);
                check("rand_settle_y", ypos, m_y);
            end
            if ($urandom_range(0, 2) == 0) set_cfg(1, 0, 0, 0, int'($urandom_range(0, 1100)));
            if ($urandom_range(0, 2) == 0) set_cfg(0, 1, 0, 0, int'($urandom_range(0, 1100)));
            do_move(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
